// File: rtl/lab5_controller.sv
// lab5_controller: instruction decode for R-type ALU ops plus sequencing of a
// fixed-latency multiply/divide unit that writes HI/LO.
module lab5_controller #(
   parameter int unsigned MULT_LAT = 4,
   parameter int unsigned DIV_LAT  = 12
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       instr_valid,
   input  logic [5:0] op_code,
   input  logic [4:0] shift_amount,
   input  logic [5:0] function_code,
   output logic       instr_ready,
   output logic [3:0] alu_op,
   output logic [4:0] alu_shamt,
   output logic [1:0] regsel,
   output logic       regwrite,
   output logic       md_start,
   output logic       md_div,
   output logic       md_signed,
   output logic       enhilo,
   output logic       md_busy,
   output logic       illegal
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     r_state;
   logic [3:0] r_cnt;

   logic [3:0] w_alu_op;
   logic       w_alu_fc;
   logic       w_md_fc;
   logic       w_mfhi_fc;
   logic       w_mflo_fc;
   logic       w_legal;
   logic       w_is_md;
   logic       w_is_mfhi;
   logic       w_is_mflo;
   logic       w_active;

   // Function-code decode: ALU operation select and instruction class flags
   always_comb begin
      w_alu_op  = '0;
      w_alu_fc  = 1'b0;
      w_md_fc   = 1'b0;
      w_mfhi_fc = 1'b0;
      w_mflo_fc = 1'b0;
      case (function_code)
         6'b100000, 6'b100001: begin w_alu_op = 4'b0100; w_alu_fc = 1'b1; end
         6'b100010, 6'b100011: begin w_alu_op = 4'b0101; w_alu_fc = 1'b1; end
         6'b100100:            begin w_alu_op = 4'b0000; w_alu_fc = 1'b1; end
         6'b100101:            begin w_alu_op = 4'b0001; w_alu_fc = 1'b1; end
         6'b100111:            begin w_alu_op = 4'b0010; w_alu_fc = 1'b1; end
         6'b100110:            begin w_alu_op = 4'b0011; w_alu_fc = 1'b1; end
         6'b101010:            begin w_alu_op = 4'b1100; w_alu_fc = 1'b1; end
         6'b101011:            begin w_alu_op = 4'b1101; w_alu_fc = 1'b1; end
         6'b000000:            begin w_alu_op = 4'b1000; w_alu_fc = 1'b1; end
         6'b000010:            begin w_alu_op = 4'b1001; w_alu_fc = 1'b1; end
         6'b000011:            begin w_alu_op = 4'b1010; w_alu_fc = 1'b1; end
         6'b011000, 6'b011010: begin w_alu_op = 4'b0110; w_md_fc  = 1'b1; end
         6'b011001, 6'b011011: begin w_alu_op = 4'b0111; w_md_fc  = 1'b1; end
         6'b010000:            w_mfhi_fc = 1'b1;
         6'b010010:            w_mflo_fc = 1'b1;
         default:              w_alu_op  = '0;
      endcase
   end

   assign w_legal   = (op_code == '0) & (w_alu_fc | w_md_fc | w_mfhi_fc | w_mflo_fc);
   assign w_is_md   = w_legal & w_md_fc;
   assign w_is_mfhi = w_legal & w_mfhi_fc;
   assign w_is_mflo = w_legal & w_mflo_fc;
   assign w_active  = instr_valid & reset_n;

   assign alu_op    = w_alu_op;
   assign alu_shamt = shift_amount;
   assign illegal   = w_active & ~w_legal;
   // Illegal encodings never count as HI/LO users, so they are never stalled.
   assign instr_ready = w_active & ~(md_busy & (w_is_md | w_is_mfhi | w_is_mflo));
   assign regwrite  = instr_ready & w_legal & ~w_is_md;
   assign regsel    = w_is_mfhi ? 2'b01 : (w_is_mflo ? 2'b10 : 2'b00);
   assign md_start  = instr_ready & w_is_md;
   assign md_div    = function_code[1];
   assign md_signed = ~function_code[0];
   assign md_busy   = (r_state == BUSY);
   assign enhilo    = md_busy & (r_cnt == '0);

   // Multiply/divide sequencer: count down the unit latency, release on cnt==0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (md_start) begin
                  r_state <= BUSY;
                  r_cnt   <= function_code[1] ? 4'(DIV_LAT - 1) : 4'(MULT_LAT - 1);
               end
            end
            BUSY: begin
               if (r_cnt != '0) r_cnt   <= r_cnt - 4'd1;
               else             r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lab5_controller.sv
// tb_lab5_controller: table-driven decode vectors plus hand-written
// multiply/divide sequencing, stall and reset sequences.
module tb_lab5_controller;

   logic       clk;
   logic       reset_n;
   logic       instr_valid;
   logic [5:0] op_code;
   logic [4:0] shift_amount;
   logic [5:0] function_code;
   logic       instr_ready;
   logic [3:0] alu_op;
   logic [4:0] alu_shamt;
   logic [1:0] regsel;
   logic       regwrite;
   logic       md_start;
   logic       md_div;
   logic       md_signed;
   logic       enhilo;
   logic       md_busy;
   logic       illegal;

   int n_checks = 0;
   int n_errors = 0;

   lab5_controller #(.MULT_LAT(4), .DIV_LAT(12)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .instr_valid  (instr_valid),
      .op_code      (op_code),
      .shift_amount (shift_amount),
      .function_code(function_code),
      .instr_ready  (instr_ready),
      .alu_op       (alu_op),
      .alu_shamt    (alu_shamt),
      .regsel       (regsel),
      .regwrite     (regwrite),
      .md_start     (md_start),
      .md_div       (md_div),
      .md_signed    (md_signed),
      .enhilo       (enhilo),
      .md_busy      (md_busy),
      .illegal      (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       v;
      logic [5:0] op;
      logic [4:0] sh;
      logic [5:0] fc;
      logic       rdy;
      logic [3:0] aop;
      logic [1:0] rs;
      logic       rw;
      logic       ms;
      logic       ill;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(string name, logic v, logic [5:0] op, logic [4:0] sh,
                               logic [5:0] fc, logic rdy, logic [3:0] aop,
                               logic [1:0] rs, logic rw, logic ms, logic ill);
      vec_t t;
      t.name = name; t.v = v; t.op = op; t.sh = sh; t.fc = fc;
      t.rdy = rdy; t.aop = aop; t.rs = rs; t.rw = rw; t.ms = ms; t.ill = ill;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] sh,
                        input logic [5:0] fc);
      instr_valid   = v;
      op_code       = op;
      shift_amount  = sh;
      function_code = fc;
   endtask

   // Advance to the next negedge (mid-cycle), apply inputs, settle 1 unit.
   task automatic step(input logic v, input logic [5:0] op, input logic [4:0] sh,
                       input logic [5:0] fc);
      @(negedge clk);
      drive(v, op, sh, fc);
      #1;
   endtask

   localparam logic [5:0] FC_MULT = 6'b011000;
   localparam logic [5:0] FC_DIVU = 6'b011011;
   localparam logic [5:0] FC_MFHI = 6'b010000;
   localparam logic [5:0] FC_MFLO = 6'b010010;
   localparam logic [5:0] FC_XOR  = 6'b100110;

   initial begin
      reset_n = 1'b0;
      drive(1'b0, 6'd0, 5'd0, 6'd0);

      // Reset state, and outputs gated while reset is held
      #1;
      chk("rst_busy", md_busy, 1'b0);
      chk("rst_enhilo", enhilo, 1'b0);
      drive(1'b1, 6'd0, 5'd3, 6'b100000);
      #1;
      chk("rst_ready", instr_ready, 1'b0);
      chk("rst_regwrite", regwrite, 1'b0);
      chk("rst_illegal", illegal, 1'b0);
      drive(1'b1, 6'd0, 5'd0, FC_MULT);
      #1;
      chk("rst_md_start", md_start, 1'b0);
      drive(1'b0, 6'd0, 5'd0, 6'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rst_busy_after", md_busy, 1'b0);

      //          name     v   op         sh     fc         rdy aop      rs     rw ms ill
      tbl.push_back(mk("add",   1, 6'd0,  5'd3,  6'b100000, 1, 4'b0100, 2'b00, 1, 0, 0));
      tbl.push_back(mk("addu",  1, 6'd0,  5'd0,  6'b100001, 1, 4'b0100, 2'b00, 1, 0, 0));
      tbl.push_back(mk("sub",   1, 6'd0,  5'd0,  6'b100010, 1, 4'b0101, 2'b00, 1, 0, 0));
      tbl.push_back(mk("subu",  1, 6'd0,  5'd0,  6'b100011, 1, 4'b0101, 2'b00, 1, 0, 0));
      tbl.push_back(mk("and",   1, 6'd0,  5'd0,  6'b100100, 1, 4'b0000, 2'b00, 1, 0, 0));
      tbl.push_back(mk("or",    1, 6'd0,  5'd0,  6'b100101, 1, 4'b0001, 2'b00, 1, 0, 0));
      tbl.push_back(mk("nor",   1, 6'd0,  5'd0,  6'b100111, 1, 4'b0010, 2'b00, 1, 0, 0));
      tbl.push_back(mk("xor",   1, 6'd0,  5'd0,  6'b100110, 1, 4'b0011, 2'b00, 1, 0, 0));
      tbl.push_back(mk("slt",   1, 6'd0,  5'd0,  6'b101010, 1, 4'b1100, 2'b00, 1, 0, 0));
      tbl.push_back(mk("sltu",  1, 6'd0,  5'd0,  6'b101011, 1, 4'b1101, 2'b00, 1, 0, 0));
      tbl.push_back(mk("sll",   1, 6'd0,  5'd5,  6'b000000, 1, 4'b1000, 2'b00, 1, 0, 0));
      tbl.push_back(mk("srl",   1, 6'd0,  5'd1,  6'b000010, 1, 4'b1001, 2'b00, 1, 0, 0));
      tbl.push_back(mk("sra",   1, 6'd0,  5'd31, 6'b000011, 1, 4'b1010, 2'b00, 1, 0, 0));
      tbl.push_back(mk("mfhi",  1, 6'd0,  5'd0,  FC_MFHI,   1, 4'b0000, 2'b01, 1, 0, 0));
      tbl.push_back(mk("mflo",  1, 6'd0,  5'd0,  FC_MFLO,   1, 4'b0000, 2'b10, 1, 0, 0));
      tbl.push_back(mk("ill_op",1, 6'b001000, 5'd0, 6'b100000, 1, 4'b0100, 2'b00, 0, 0, 1));
      tbl.push_back(mk("ill_fc",1, 6'd0,  5'd0,  6'b111111, 1, 4'b0000, 2'b00, 0, 0, 1));
      tbl.push_back(mk("ill_md",1, 6'b001000, 5'd0, FC_MULT, 1, 4'b0110, 2'b00, 0, 0, 1));
      tbl.push_back(mk("novld", 0, 6'd0,  5'd7,  6'b100000, 0, 4'b0100, 2'b00, 0, 0, 0));

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].op, tbl[i].sh, tbl[i].fc);
         chk({tbl[i].name, "_ready"},    instr_ready, tbl[i].rdy);
         chk({tbl[i].name, "_alu_op"},   alu_op,      tbl[i].aop);
         chk({tbl[i].name, "_shamt"},    alu_shamt,   tbl[i].sh);
         chk({tbl[i].name, "_regsel"},   regsel,      tbl[i].rs);
         chk({tbl[i].name, "_regwrite"}, regwrite,    tbl[i].rw);
         chk({tbl[i].name, "_md_start"}, md_start,    tbl[i].ms);
         chk({tbl[i].name, "_illegal"},  illegal,     tbl[i].ill);
      end
      step(1'b0, 6'd0, 5'd0, 6'd0);
      chk("tbl_busy_idle", md_busy, 1'b0);

      // mult accepted at cycle 0: busy cycles 1..4, enhilo only at 4
      step(1'b1, 6'd0, 5'd0, FC_MULT);
      chk("mult_start", md_start, 1'b1);
      chk("mult_signed", md_signed, 1'b1);
      chk("mult_div", md_div, 1'b0);
      chk("mult_ready", instr_ready, 1'b1);
      chk("mult_rw", regwrite, 1'b0);
      chk("mult_aop", alu_op, 4'b0110);
      for (int k = 1; k <= 5; k++) begin
         step(1'b0, 6'd0, 5'd0, 6'd0);
         chk($sformatf("mult_busy_c%0d", k), md_busy, (k <= 4));
         chk($sformatf("mult_enhilo_c%0d", k), enhilo, (k == 4));
      end

      // divu accepted at cycle 0, mflo waits from cycle 1 until cycle 13
      step(1'b1, 6'd0, 5'd0, FC_DIVU);
      chk("divu_start", md_start, 1'b1);
      chk("divu_signed", md_signed, 1'b0);
      chk("divu_div", md_div, 1'b1);
      chk("divu_aop", alu_op, 4'b0111);
      for (int k = 1; k <= 13; k++) begin
         step(1'b1, 6'd0, 5'd0, FC_MFLO);
         chk($sformatf("mflo_ready_c%0d", k), instr_ready, (k == 13));
         chk($sformatf("mflo_rw_c%0d", k), regwrite, (k == 13));
         chk($sformatf("mflo_enhilo_c%0d", k), enhilo, (k == 12));
         chk($sformatf("mflo_busy_c%0d", k), md_busy, (k <= 12));
      end
      chk("mflo_regsel", regsel, 2'b10);
      chk("mflo_md_start", md_start, 1'b0);

      // xor during BUSY flows through; mfhi stalls on the enhilo cycle
      step(1'b1, 6'd0, 5'd0, FC_MULT);
      chk("mx_start", md_start, 1'b1);
      step(1'b0, 6'd0, 5'd0, 6'd0);
      chk("mx_busy_c1", md_busy, 1'b1);
      step(1'b1, 6'd0, 5'd2, FC_XOR);
      chk("mx_xor_ready_c2", instr_ready, 1'b1);
      chk("mx_xor_aop_c2", alu_op, 4'b0011);
      chk("mx_xor_rw_c2", regwrite, 1'b1);
      chk("mx_enhilo_c2", enhilo, 1'b0);
      step(1'b1, 6'd0, 5'd2, FC_XOR);
      chk("mx_xor_ready_c3", instr_ready, 1'b1);
      chk("mx_enhilo_c3", enhilo, 1'b0);
      step(1'b1, 6'd0, 5'd0, FC_MFHI);
      chk("mx_enhilo_c4", enhilo, 1'b1);
      chk("mx_busy_c4", md_busy, 1'b1);
      chk("mx_mfhi_ready_c4", instr_ready, 1'b0);
      chk("mx_mfhi_rw_c4", regwrite, 1'b0);
      step(1'b1, 6'd0, 5'd0, FC_MFHI);
      chk("mx_mfhi_ready_c5", instr_ready, 1'b1);
      chk("mx_mfhi_rw_c5", regwrite, 1'b1);
      chk("mx_mfhi_regsel_c5", regsel, 2'b01);
      chk("mx_busy_c5", md_busy, 1'b0);
      chk("mx_enhilo_c5", enhilo, 1'b0);

      // Reset at cycle 2 of a mult discards the result
      step(1'b1, 6'd0, 5'd0, FC_MULT);
      chk("rm_start", md_start, 1'b1);
      step(1'b0, 6'd0, 5'd0, 6'd0);
      chk("rm_busy_c1", md_busy, 1'b1);
      @(negedge clk);
      reset_n = 1'b0;
      drive(1'b1, 6'd0, 5'd0, FC_MULT);
      #1;
      chk("rm_busy_rst", md_busy, 1'b0);
      chk("rm_enhilo_rst", enhilo, 1'b0);
      chk("rm_start_rst", md_start, 1'b0);
      chk("rm_ready_rst", instr_ready, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b0, 6'd0, 5'd0, 6'd0);
      #1;
      for (int k = 4; k <= 7; k++) begin
         step(1'b0, 6'd0, 5'd0, 6'd0);
         chk($sformatf("rm_enhilo_c%0d", k), enhilo, 1'b0);
         chk($sformatf("rm_busy_c%0d", k), md_busy, 1'b0);
      end
      step(1'b1, 6'd0, 5'd0, 6'b011001);
      chk("rm2_start", md_start, 1'b1);
      chk("rm2_signed", md_signed, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         step(1'b0, 6'd0, 5'd0, 6'd0);
         chk($sformatf("rm2_busy_c%0d", k), md_busy, (k <= 4));
         chk($sformatf("rm2_enhilo_c%0d", k), enhilo, (k == 4));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
